alu_wide_sequencer: RTL and testbench

//  Initiator for the 8-bit combinational ALU. Takes one NBYTES-wide command over valid/ready,

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/alu_seq_byte_lane.sv | 25 ++
 rtl/alu_wide_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_wide_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and parameter legality check for alu_wide_sequencer
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    function automatic bit nbytes_ok(int n);
        return n >= 1 && n <= 4;
    endfunction
endpackage

// File: rtl/alu_seq_byte_lane.sv
// alu_seq_byte_lane: picks the operand bytes for pass k (SHR walks MSB->LSB) and merges the chained bit
module alu_seq_byte_lane
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   k_i,
    input  logic         chain_i,
    input  logic [7:0]   alu_result_i,
    output logic [1:0]   lane_o,
    output logic [7:0]   a_byte_o,
    output logic [7:0]   b_byte_o,
    output logic [7:0]   res_byte_o
);
    assign lane_o   = op_i == OP_SHR ? 2'(NBYTES - 1) - k_i : k_i;
    assign a_byte_o = a_i[int'(lane_o) * 8 +: 8];
    // SUB is built as A + ~B + 1 so the ALU only ever sees ADD for arithmetic
    assign b_byte_o = op_i == OP_SUB ? ~b_i[int'(lane_o) * 8 +: 8] : b_i[int'(lane_o) * 8 +: 8];
    assign res_byte_o = op_i == OP_SHL ? alu_result_i | {7'b0, chain_i} :
                        op_i == OP_SHR ? alu_result_i | {chain_i, 7'b0} : alu_result_i;
endmodule

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs an NBYTES-wide command through an 8-bit ALU one byte per cycle.
// Define ALU_SEQ_B2B_EN to accept the next command on the response handshake edge.
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [W-1:0] cmd_a_i,
    input  logic [W-1:0] cmd_b_i,
    input  logic         cmd_cin_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_result_o,
    output logic         rsp_cout_o,
    output logic         rsp_zero_o,
    output logic         rsp_neg_o,
    output logic         rsp_ovf_o,
    output logic [7:0]   alu_a_o,
    output logic [7:0]   alu_b_o,
    output logic [2:0]   alu_sel_o,
    output logic         alu_cin_o,
    input  logic [7:0]   alu_result_i,
    input  logic         alu_cout_i,
    input  logic         alu_overflow_i
);
    if (!nbytes_ok(NBYTES)) begin : g_bad_nbytes
        $error("alu_wide_sequencer: NBYTES must be 1..4");
    end

    localparam logic [1:0] LAST = 2'(NBYTES - 1);

    state_e state_q, state_d;
    logic [1:0] k_q, lane;
    logic [2:0] op_q;
    logic [W-1:0] a_q, b_q, res_q, res_d, rsp_result_q;
    logic cin_q, c_q, cout_q, zero_q, neg_q, ovf_q;
    logic accept, exec, last, chain, cout_d;
    logic [7:0] a_byte, b_byte, res_byte;

    assign accept = cmd_valid_i & cmd_ready_o;
    assign exec   = state_q == EXEC;
    assign last   = k_q == LAST;
    // first pass seeds the chain: cin for ADD, the +1 of two's complement for SUB, 0 for shifts
    assign chain  = k_q == 2'd0 ? (op_q == OP_ADD ? cin_q : op_q == OP_SUB) : c_q;

    alu_seq_byte_lane #(.NBYTES(NBYTES)) u_lane (
        .op_i(op_q), .a_i(a_q), .b_i(b_q), .k_i(k_q), .chain_i(chain),
        .alu_result_i(alu_result_i), .lane_o(lane),
        .a_byte_o(a_byte), .b_byte_o(b_byte), .res_byte_o(res_byte)
    );

    assign alu_a_o   = exec ? a_byte : 8'h0;
    assign alu_b_o   = exec ? b_byte : 8'h0;
    assign alu_sel_o = exec ? (op_q == OP_SUB ? OP_ADD : op_q) : 3'd0;
    assign alu_cin_o = exec & (op_q == OP_ADD | op_q == OP_SUB) & chain;

    always_comb begin
        res_d = res_q;
        res_d[int'(lane) * 8 +: 8] = res_byte;
    end

    // SUB reports borrow, the inverse of the final adder carry
    assign cout_d = op_q == OP_SUB ? ~alu_cout_i : (op_q inside {OP_ADD, OP_SHL, OP_SHR}) & alu_cout_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = last ? DONE : EXEC;
            DONE:    state_d = rsp_ready_i ? (accept ? EXEC : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_o = state_q == DONE;
`ifdef ALU_SEQ_B2B_EN
        cmd_ready_o = state_q == IDLE || (state_q == DONE && rsp_ready_i);
`else
        cmd_ready_o = state_q == IDLE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            c_q          <= 1'b0;
            res_q        <= '0;
            rsp_result_q <= '0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (accept) begin
                k_q   <= '0;
                op_q  <= cmd_op_i;
                a_q   <= cmd_a_i;
                b_q   <= cmd_b_i;
                cin_q <= cmd_cin_i;
            end else if (exec) begin
                k_q   <= k_q + 2'd1;
                c_q   <= alu_cout_i;
                res_q <= res_d;
            end
            if (exec && last) begin
                rsp_result_q <= res_d;
                cout_q       <= cout_d;
                zero_q       <= res_d == '0;
                neg_q        <= res_d[W-1];
                ovf_q        <= (op_q == OP_ADD | op_q == OP_SUB) & alu_overflow_i;
            end
        end
    end

    assign rsp_result_o = rsp_result_q;
    assign rsp_cout_o   = cout_q;
    assign rsp_zero_o   = zero_q;
    assign rsp_neg_o    = neg_q;
    assign rsp_ovf_o    = ovf_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: scoreboard bench with an attached 8-bit ALU model and a wide-arithmetic reference
module tb_alu_wide_sequencer;
    localparam int NBYTES = 2;
    localparam int W = 8 * NBYTES;
`ifdef ALU_SEQ_B2B_EN
    localparam int GAP = NBYTES + 1;
`else
    localparam int GAP = NBYTES + 2;
`endif

    typedef struct {
        logic [W+3:0] v;
        string        name;
    } exp_t;

    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_ready, cmd_cin = 0;
    logic [2:0] cmd_op = 0;
    logic [W-1:0] cmd_a = 0, cmd_b = 0;
    logic rsp_valid, rsp_ready = 0, rsp_cout, rsp_zero, rsp_neg, rsp_ovf;
    logic [W-1:0] rsp_result;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic alu_cin, alu_cout, alu_ovf;

    int n_chk = 0, n_pass = 0, cyc = 0;
    exp_t exp_q[$];
    int acc_q[$];
    int rise_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_wide_sequencer #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_cin_i(cmd_cin),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_cout_o(rsp_cout), .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg), .rsp_ovf_o(rsp_ovf),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .alu_cin_o(alu_cin),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout), .alu_overflow_i(alu_ovf)
    );

    // the 8-bit combinational ALU the sequencer drives
    always_comb begin
        logic [8:0] s;
        s = 9'h0;
        alu_cout = 1'b0;
        alu_ovf = 1'b0;
        case (alu_sel)
            3'd0: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h0, alu_cin};
                alu_result = s[7:0];
                alu_cout = s[8];
                alu_ovf = alu_a[7] == alu_b[7] && alu_result[7] != alu_a[7];
            end
            3'd1: begin
                alu_result = alu_a - alu_b;
                alu_cout = alu_a < alu_b;
                alu_ovf = alu_a[7] != alu_b[7] && alu_result[7] != alu_a[7];
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: begin alu_result = alu_a << 1; alu_cout = alu_a[7]; end
            default: begin alu_result = alu_a >> 1; alu_cout = alu_a[0]; end
        endcase
    end

    function automatic logic [W+3:0] ref_model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        logic [W:0] s;
        logic [W-1:0] r;
        logic co, ov;
        co = 0;
        ov = 0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                r = s[W-1:0];
                co = s[W];
                ov = a[W-1] == b[W-1] && r[W-1] != a[W-1];
            end
            3'd1: begin
                r = a - b;
                co = a < b;
                ov = a[W-1] != b[W-1] && r[W-1] != a[W-1];
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = a << 1; co = a[W-1]; end
            default: begin r = a >> 1; co = a[0]; end
        endcase
        return {r, co, r == '0, r[W-1], ov};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: latency on each rising rsp_valid, scoreboard pop on each handshake
    logic prev_v = 0;
    always begin
        int a;
        exp_t e;
        @(negedge clk);
        #1;
        if (rsp_valid && !prev_v) begin
            rise_q.push_back(cyc);
            if (acc_q.size() > 0) begin
                a = acc_q.pop_front();
                chk("latency", 64'(cyc - a), 64'(NBYTES));
            end else chk("rsp_valid without accept", 1, 0);
        end
        prev_v = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, 64'({rsp_result, rsp_cout, rsp_zero, rsp_neg, rsp_ovf}), 64'(e.v));
            end else chk("unexpected response", 1, 0);
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input string name);
        exp_t e;
        bit ok;
        ok = 0;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_cin = cin;
        cmd_valid = 1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk({"accept timeout ", name}, 1, 0);
        else begin
            e.v = ref_model(op, a, b, cin);
            e.name = name;
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        chk("drain timeout", 64'(exp_q.size()), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int seen, nr;
        logic [W+3:0] hold_exp;
        repeat (2) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp", 64'({rsp_result, rsp_cout, rsp_zero, rsp_neg, rsp_ovf}), 0);
        chk("reset alu", 64'({alu_a, alu_b, alu_sel, alu_cin}), 0);
        rst = 0;
        @(negedge clk);

        send(3'd0, 16'h00FF, 16'h0001, 0, "add carry across bytes");
        drain(0);
        send(3'd1, 16'h0000, 16'h0001, 0, "sub borrow");
        drain(0);
        send(3'd1, 16'h8000, 16'h0001, 0, "sub overflow");
        drain(0);
        send(3'd6, 16'h4080, 16'h0000, 0, "shl");
        drain(0);
        send(3'd7, 16'h0101, 16'h0000, 0, "shr");
        drain(0);
        send(3'd0, 16'hFFFF, 16'h0000, 1, "add cin wrap");
        drain(0);
        send(3'd0, 16'h7FFF, 16'h0001, 0, "add overflow");
        drain(0);
        send(3'd4, 16'hA5A5, 16'hA5A5, 0, "xor zero");
        drain(0);
        send(3'd5, 16'h1234, 16'h0000, 1, "not");
        drain(0);

        // hold the response off and check it stays put with cmd_ready low
        rsp_ready = 0;
        hold_exp = ref_model(3'd1, 16'h1200, 16'h0034, 0);
        send(3'd1, 16'h1200, 16'h0034, 0, "sub after hold");
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold rsp_valid", rsp_valid, 1);
            chk("hold rsp", 64'({rsp_result, rsp_cout, rsp_zero, rsp_neg, rsp_ovf}), 64'(hold_exp));
            chk("hold cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        drain(0);

        // reset in the middle of EXEC discards the command
        rsp_ready = 1;
        send(3'd0, 16'h1111, 16'h2222, 0, "discarded");
        rst = 1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst alu", 64'({alu_a, alu_b, alu_sel, alu_cin}), 0);
        chk("midrst cmd_ready", cmd_ready, 1);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no stale response", 64'(seen), 0);

        // back-to-back throughput
        rsp_ready = 1;
        nr = rise_q.size();
        send(3'd0, 16'h0102, 16'h0304, 0, "b2b first");
        send(3'd3, 16'hF000, 16'h000F, 0, "b2b second");
        drain(0);
        chk("b2b response count", 64'(rise_q.size() - nr), 2);
        if (rise_q.size() - nr == 2)
            chk("b2b spacing", 64'(rise_q[nr+1] - rise_q[nr]), 64'(GAP));

        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), "random");
            drain(1);
        end
        rsp_ready = 1;
        drain(0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
